// File: rtl/spu_forward_unit.sv
// Result-tracking forwarding and interlock unit for the dual-issue SPU pipeline.
// Every register-writing instruction issued on pipe 1 (even) or pipe 2 (odd)
// enters a per-pipe shift chain, and the chain captures its result when the
// pipe delivers it. Six operand queries are resolved against the chains. A hit
// on a finished entry forwards its data. A hit on an unfinished entry stalls.
module spu_forward_unit #(
    parameter int DEPTH = 7,
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             issue_valid_1,
    input  logic             issue_we_1,
    input  logic [6:0]       issue_rt_1,
    input  logic [2:0]       issue_lat_1,
    input  logic             issue_valid_2,
    input  logic             issue_we_2,
    input  logic [6:0]       issue_rt_2,
    input  logic [2:0]       issue_lat_2,
    input  logic             result_valid_1,
    input  logic [WIDTH-1:0] result_data_1,
    input  logic             result_valid_2,
    input  logic [WIDTH-1:0] result_data_2,
    input  logic [6:0]       query_ra_1,
    input  logic [6:0]       query_rb_1,
    input  logic [6:0]       query_rc_1,
    input  logic [6:0]       query_ra_2,
    input  logic [6:0]       query_rb_2,
    input  logic [6:0]       query_rc_2,
    output logic [WIDTH-1:0] fwd_data_ra_1,
    output logic [WIDTH-1:0] fwd_data_rb_1,
    output logic [WIDTH-1:0] fwd_data_rc_1,
    output logic [WIDTH-1:0] fwd_data_ra_2,
    output logic [WIDTH-1:0] fwd_data_rb_2,
    output logic [WIDTH-1:0] fwd_data_rc_2,
    output logic             fwd_sel_ra_1,
    output logic             fwd_sel_rb_1,
    output logic             fwd_sel_rc_1,
    output logic             fwd_sel_ra_2,
    output logic             fwd_sel_rb_2,
    output logic             fwd_sel_rc_2,
    output logic             stall
);

    // Per-pipe views of the issue and result ports. Index 0 is pipe 1 and index 1 is pipe 2.
    logic             issue_go  [2];
    logic [6:0]       issue_rt  [2];
    logic [2:0]       issue_lat [2];
    logic             res_valid [2];
    logic [WIDTH-1:0] res_data  [2];

    // A stalled or flushed issue is dropped. The upstream stage re-presents a stalled instruction.
    assign issue_go[0]  = issue_valid_1 & issue_we_1 & ~stall & ~flush;
    assign issue_go[1]  = issue_valid_2 & issue_we_2 & ~stall & ~flush;
    assign issue_rt[0]  = issue_rt_1;
    assign issue_rt[1]  = issue_rt_2;
    assign issue_lat[0] = issue_lat_1;
    assign issue_lat[1] = issue_lat_2;
    assign res_valid[0] = result_valid_1;
    assign res_valid[1] = result_valid_2;
    assign res_data[0]  = result_data_1;
    assign res_data[1]  = result_data_2;

    // Shift-chain state. Stage 0 holds the youngest entry.
    logic             valid_reg [2][DEPTH];
    logic [6:0]       rt_reg    [2][DEPTH];
    logic [2:0]       cnt_reg   [2][DEPTH];
    logic             rdy_reg   [2][DEPTH];
    logic [WIDTH-1:0] data_reg  [2][DEPTH];

    // Advance both chains one stage, load new issues at stage 0, and capture results that come due.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < 2; p++) begin
                for (int s = 0; s < DEPTH; s++) begin
                    valid_reg[p][s] <= 1'b0;
                    rt_reg[p][s]    <= 7'd0;
                    cnt_reg[p][s]   <= 3'd0;
                    rdy_reg[p][s]   <= 1'b0;
                    data_reg[p][s]  <= '0;
                end
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                for (int s = DEPTH - 1; s >= 1; s--) begin
                    valid_reg[p][s] <= valid_reg[p][s-1] & ~flush;
                    rt_reg[p][s]    <= rt_reg[p][s-1];
                    cnt_reg[p][s]   <= (cnt_reg[p][s-1] == 3'd0) ? 3'd0 : cnt_reg[p][s-1] - 3'd1;
                    if (valid_reg[p][s-1] && cnt_reg[p][s-1] == 3'd1 && res_valid[p]) begin
                        rdy_reg[p][s]  <= 1'b1;
                        data_reg[p][s] <= res_data[p];
                    end else begin
                        rdy_reg[p][s]  <= rdy_reg[p][s-1];
                        data_reg[p][s] <= data_reg[p][s-1];
                    end
                end
                valid_reg[p][0] <= issue_go[p];
                rt_reg[p][0]    <= issue_rt[p];
                cnt_reg[p][0]   <= issue_lat[p];
                rdy_reg[p][0]   <= 1'b0;
                data_reg[p][0]  <= '0;
            end
        end
    end

    // A result that comes due while its pipe presents nothing is a protocol error.
    always_ff @(posedge clk) begin
        if (!reset && !flush) begin
            for (int p = 0; p < 2; p++) begin
                for (int s = 0; s < DEPTH; s++) begin
                    assert (!(valid_reg[p][s] && cnt_reg[p][s] == 3'd1 && !res_valid[p]));
                end
            end
        end
    end

    // Query order: RA_1, RB_1, RC_1, RA_2, RB_2, RC_2.
    logic [6:0]       query     [6];
    logic [WIDTH-1:0] fwd_data_q[6];
    logic             fwd_sel_q [6];
    logic [5:0]       pend_vec;

    assign query[0] = query_ra_1;
    assign query[1] = query_rb_1;
    assign query[2] = query_rc_1;
    assign query[3] = query_ra_2;
    assign query[4] = query_rb_2;
    assign query[5] = query_rc_2;

    for (genvar gi = 0; gi < 6; gi++) begin : g_query
        logic             found;
        logic             found_rdy;
        logic [WIDTH-1:0] found_data;

        // Scan from oldest to youngest so that the youngest hit wins. Pipe 2 is scanned after pipe 1 at each stage.
        always_comb begin
            found      = 1'b0;
            found_rdy  = 1'b0;
            found_data = '0;
            for (int s = DEPTH - 1; s >= 0; s--) begin
                for (int p = 0; p < 2; p++) begin
                    if (valid_reg[p][s] && rt_reg[p][s] == query[gi]) begin
                        found      = 1'b1;
                        found_rdy  = rdy_reg[p][s];
                        found_data = data_reg[p][s];
                    end
                end
            end
        end

        assign fwd_sel_q[gi]  = found & found_rdy;
        assign fwd_data_q[gi] = (found & found_rdy) ? found_data : '0;
        assign pend_vec[gi]   = found & ~found_rdy;
    end

    assign stall = |pend_vec;

    assign fwd_data_ra_1 = fwd_data_q[0];
    assign fwd_data_rb_1 = fwd_data_q[1];
    assign fwd_data_rc_1 = fwd_data_q[2];
    assign fwd_data_ra_2 = fwd_data_q[3];
    assign fwd_data_rb_2 = fwd_data_q[4];
    assign fwd_data_rc_2 = fwd_data_q[5];
    assign fwd_sel_ra_1  = fwd_sel_q[0];
    assign fwd_sel_rb_1  = fwd_sel_q[1];
    assign fwd_sel_rc_1  = fwd_sel_q[2];
    assign fwd_sel_ra_2  = fwd_sel_q[3];
    assign fwd_sel_rb_2  = fwd_sel_q[4];
    assign fwd_sel_rc_2  = fwd_sel_q[5];

endmodule

// File: tb/tb_spu_forward_unit.sv
// Testbench for spu_forward_unit. The model keeps a list of issued instructions,
// each stored with its issue edge and latency. From that list it derives the
// forwarding and stall response expected in each cycle. A monitor compares the
// DUT outputs against queued expectations on the falling edge.
module tb_spu_forward_unit;
    localparam int DEPTH = 7;
    localparam int WIDTH = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic             flush;
    logic             issue_valid  [2];
    logic             issue_we     [2];
    logic [6:0]       issue_rt     [2];
    logic [2:0]       issue_lat    [2];
    logic             result_valid [2];
    logic [WIDTH-1:0] result_data  [2];
    logic [6:0]       query        [6];
    logic [WIDTH-1:0] fwd_data     [6];
    logic             fwd_sel      [6];
    logic             stall;

    spu_forward_unit #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .issue_valid_1(issue_valid[0]), .issue_we_1(issue_we[0]),
        .issue_rt_1(issue_rt[0]), .issue_lat_1(issue_lat[0]),
        .issue_valid_2(issue_valid[1]), .issue_we_2(issue_we[1]),
        .issue_rt_2(issue_rt[1]), .issue_lat_2(issue_lat[1]),
        .result_valid_1(result_valid[0]), .result_data_1(result_data[0]),
        .result_valid_2(result_valid[1]), .result_data_2(result_data[1]),
        .query_ra_1(query[0]), .query_rb_1(query[1]), .query_rc_1(query[2]),
        .query_ra_2(query[3]), .query_rb_2(query[4]), .query_rc_2(query[5]),
        .fwd_data_ra_1(fwd_data[0]), .fwd_data_rb_1(fwd_data[1]), .fwd_data_rc_1(fwd_data[2]),
        .fwd_data_ra_2(fwd_data[3]), .fwd_data_rb_2(fwd_data[4]), .fwd_data_rc_2(fwd_data[5]),
        .fwd_sel_ra_1(fwd_sel[0]), .fwd_sel_rb_1(fwd_sel[1]), .fwd_sel_rc_1(fwd_sel[2]),
        .fwd_sel_ra_2(fwd_sel[3]), .fwd_sel_rb_2(fwd_sel[4]), .fwd_sel_rc_2(fwd_sel[5]),
        .stall(stall)
    );

    // An instruction that the model has accepted: pipe 1 or 2, issued at edge t.
    typedef struct {
        int               pipe;
        logic [6:0]       rt;
        int               t;
        int               lat;
        logic [WIDTH-1:0] data;
    } ent_t;

    typedef struct packed {
        logic [5:0]            sel;
        logic [5:0][WIDTH-1:0] data;
        logic                  stall;
    } exp_t;

    ent_t ents [$];
    exp_t sb   [$];
    exp_t mon_e;
    int   cur;
    int   n_checks;
    int   n_fail;

    // Stimulus for the next cycle. Index 0 is pipe 1.
    bit               s_rst, s_fl;
    bit               s_iv [2], s_we [2], s_spur [2], s_force [2];
    logic [6:0]       s_rt [2];
    int               s_lat [2];
    logic [WIDTH-1:0] s_fdata [2];
    logic [6:0]       s_q [6];
    bit               acc [2];

    task automatic clear_stim();
        s_rst = 0;
        s_fl  = 0;
        for (int p = 0; p < 2; p++) begin
            s_iv[p] = 0; s_we[p] = 0; s_spur[p] = 0; s_force[p] = 0;
            s_rt[p] = 7'd0; s_lat[p] = 1; s_fdata[p] = '0;
        end
        for (int q = 0; q < 6; q++) s_q[q] = 7'd0;
    endtask

    // The youngest live entry for register qr decides the result. At equal age, pipe 2 wins.
    function automatic void model_lookup(input logic [6:0] qr, output bit sel,
                                         output logic [WIDTH-1:0] d, output bit pend);
        int best = -1;
        int best_age = DEPTH;
        sel = 0; d = '0; pend = 0;
        for (int i = 0; i < ents.size(); i++) begin
            int age;
            age = cur - ents[i].t;
            if (ents[i].rt == qr && age >= 0 && age < DEPTH) begin
                if (best < 0 || age < best_age || (age == best_age && ents[i].pipe > ents[best].pipe)) begin
                    best = i;
                    best_age = age;
                end
            end
        end
        if (best >= 0) begin
            if (cur >= ents[best].t + ents[best].lat) begin
                sel = 1;
                d = ents[best].data;
            end else begin
                pend = 1;
            end
        end
    endfunction

    // A pipe delivers one result per cycle, so two of its instructions must not fall due in the same cycle.
    function automatic bit issue_ok(input int p, input int lat);
        issue_ok = 1;
        foreach (ents[i])
            if (ents[i].pipe == p + 1 && ents[i].t + ents[i].lat - 1 == cur + lat) issue_ok = 0;
    endfunction

    function automatic logic [6:0] pick_rt();
        case ($urandom_range(0, 3))
            0: pick_rt = 7'd3;
            1: pick_rt = 7'd5;
            2: pick_rt = 7'd7;
            default: pick_rt = 7'd9;
        endcase
    endfunction

    // Drive one cycle. Deliver the results that fall due, queue the expected outputs, then advance the model across the edge.
    task automatic step();
        exp_t e;
        bit st, sl, pd;
        logic [WIDTH-1:0] dd;
        ent_t ne;
        reset = s_rst;
        flush = s_fl;
        for (int p = 0; p < 2; p++) begin
            issue_valid[p]  = s_iv[p];
            issue_we[p]     = s_we[p];
            issue_rt[p]     = s_rt[p];
            issue_lat[p]    = 3'(s_lat[p]);
            result_valid[p] = s_spur[p];
            result_data[p]  = {$urandom(), $urandom(), $urandom(), $urandom()};
            for (int i = 0; i < ents.size(); i++) begin
                if (ents[i].pipe == p + 1 && ents[i].t + ents[i].lat - 1 == cur) begin
                    result_valid[p] = 1;
                    if (s_force[p]) result_data[p] = s_fdata[p];
                    ents[i].data = result_data[p];
                end
            end
        end
        for (int q = 0; q < 6; q++) query[q] = s_q[q];
        e = '0;
        st = 0;
        for (int q = 0; q < 6; q++) begin
            model_lookup(s_q[q], sl, dd, pd);
            e.sel[q]  = sl;
            e.data[q] = dd;
            st = st | pd;
        end
        e.stall = st;
        sb.push_back(e);
        for (int p = 0; p < 2; p++) acc[p] = s_iv[p] && s_we[p] && !st && !s_fl && !s_rst;
        if (s_rst || s_fl) begin
            ents.delete();
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (acc[p]) begin
                    ne.pipe = p + 1; ne.rt = s_rt[p]; ne.t = cur + 1; ne.lat = s_lat[p]; ne.data = '0;
                    ents.push_back(ne);
                end
            end
        end
        @(posedge clk);
        cur++;
        for (int i = ents.size() - 1; i >= 0; i--)
            if (cur - ents[i].t >= DEPTH) ents.delete(i);
        #1;
    endtask

    task automatic check(input string name, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Compare the DUT against the oldest queued expectation, midway between edges.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            for (int q = 0; q < 6; q++) begin
                n_checks++;
                if (fwd_sel[q] !== mon_e.sel[q] || fwd_data[q] !== mon_e.data[q]) begin
                    n_fail++;
                    $display("FAIL fwd[%0d] cycle %0d: got sel=%0b data=%h, expected sel=%0b data=%h",
                             q, cur, fwd_sel[q], fwd_data[q], mon_e.sel[q], mon_e.data[q]);
                end
            end
            n_checks++;
            if (stall !== mon_e.stall) begin
                n_fail++;
                $display("FAIL stall cycle %0d: got %0b, expected %0b", cur, stall, mon_e.stall);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        n_checks = 0;
        n_fail   = 0;
        cur      = 0;
        clear_stim();
        reset = 1; flush = 0;
        for (int p = 0; p < 2; p++) begin
            issue_valid[p] = 0; issue_we[p] = 0; issue_rt[p] = 0; issue_lat[p] = 0;
            result_valid[p] = 0; result_data[p] = '0;
        end
        for (int q = 0; q < 6; q++) query[q] = 7'd0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, plus a result pulse while nothing is tracked.
        for (int q = 0; q < 6; q++) s_q[q] = 7'd5;
        step();
        s_spur[0] = 1; step();
        s_spur[0] = 0; step();

        // Pipe 1 rt=5 L=2: two stall cycles, then DEPTH-2 cycles of forwarding.
        clear_stim();
        s_iv[0] = 1; s_we[0] = 1; s_rt[0] = 7'd5; s_lat[0] = 2; s_q[0] = 7'd5;
        s_force[0] = 1; s_fdata[0] = {16{8'hA5}};
        step();
        s_iv[0] = 0;
        step(); step();
        check("a5_sel", 128'(fwd_sel[0]), 128'd1);
        check("a5_data", fwd_data[0], {16{8'hA5}});
        repeat (DEPTH) step();

        // Older pipe 1 rt=9 L=6, then younger pipe 2 rt=9 L=2 with result 0x22.
        clear_stim();
        s_iv[0] = 1; s_we[0] = 1; s_rt[0] = 7'd9; s_lat[0] = 6;
        step();
        s_iv[0] = 0;
        s_iv[1] = 1; s_we[1] = 1; s_rt[1] = 7'd9; s_lat[1] = 2;
        s_force[1] = 1; s_fdata[1] = 128'h22;
        step();
        s_iv[1] = 0; s_q[4] = 7'd9;
        step(); step();
        check("younger_p2_data", fwd_data[4], 128'h22);
        repeat (DEPTH) step();

        // Same-cycle issue on both pipes to rt=3. Pipe 2 (0x33) wins.
        clear_stim();
        for (int p = 0; p < 2; p++) begin
            s_iv[p] = 1; s_we[p] = 1; s_rt[p] = 7'd3; s_lat[p] = 1; s_force[p] = 1;
        end
        s_fdata[0] = 128'h11; s_fdata[1] = 128'h33;
        step();
        s_iv[0] = 0; s_iv[1] = 0; s_q[0] = 7'd3;
        step();
        check("same_cycle_p2_wins", fwd_data[0], 128'h33);
        repeat (DEPTH) step();

        // Issue held while stalled: accepted once the stall clears, then dropped by upstream.
        clear_stim();
        s_iv[0] = 1; s_we[0] = 1; s_rt[0] = 7'd5; s_lat[0] = 4;
        step();
        s_rt[0] = 7'd11; s_lat[0] = 1; s_q[0] = 7'd5; s_q[1] = 7'd11;
        n = 0;
        do begin
            step();
            n++;
        end while (!acc[0] && n < 20);
        n_checks++;
        if (!acc[0]) begin
            n_fail++;
            $display("FAIL held_issue: not accepted after %0d cycles, required within 20", n);
        end
        s_iv[0] = 0;
        repeat (DEPTH) step();

        // Pending rt=7 discarded by flush. A late result is then ignored.
        clear_stim();
        s_iv[0] = 1; s_we[0] = 1; s_rt[0] = 7'd7; s_lat[0] = 5;
        step();
        s_iv[0] = 0; s_q[2] = 7'd7;
        step();
        s_fl = 1; step();
        s_fl = 0; s_spur[0] = 1; step();
        check("flush_stall", 128'(stall), 128'd0);
        step();
        s_spur[0] = 0;

        // Pending rt=7 on pipe 2, discarded by a reset mid-flight.
        clear_stim();
        s_iv[1] = 1; s_we[1] = 1; s_rt[1] = 7'd7; s_lat[1] = 5;
        step();
        s_iv[1] = 0; s_q[5] = 7'd7;
        step();
        s_rst = 1; step();
        s_rst = 0; s_spur[1] = 1; step();
        check("reset_sel", 128'(fwd_sel[5]), 128'd0);
        step();

        // Randomized traffic.
        clear_stim();
        for (int k = 0; k < 400; k++) begin
            for (int p = 0; p < 2; p++) begin
                s_iv[p]   = ($urandom_range(0, 2) != 0);
                s_we[p]   = ($urandom_range(0, 3) != 0);
                s_rt[p]   = pick_rt();
                s_lat[p]  = $urandom_range(1, DEPTH);
                s_spur[p] = ($urandom_range(0, 7) == 0);
                if (!issue_ok(p, s_lat[p])) s_iv[p] = 0;
            end
            for (int q = 0; q < 6; q++)
                s_q[q] = ($urandom_range(0, 4) == 0) ? 7'($urandom_range(0, 127)) : pick_rt();
            s_fl  = ($urandom_range(0, 59) == 0);
            s_rst = ($urandom_range(0, 149) == 0);
            step();
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
